// File: rtl/dds_param_scheduler.sv
// Timed parameter source for the DDS phase MAC: free-running timestamp plus a FIFO of
// profile commands, each applied on the cycle the timestamp reaches its target time.
module dds_param_scheduler #(
    parameter int DEPTH = 8,
    parameter int TS_W  = 48
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [TS_W-1:0]            cmd_time,
    input  logic [TS_W-1:0]            cmd_freq,
    input  logic [13:0]                cmd_phase,
    input  logic                       cmd_reset_phase,
    input  logic                       flush,
    input  logic                       ts_load,
    input  logic [TS_W-1:0]            ts_load_value,
    output logic [TS_W-1:0]            timestamp,
    output logic [TS_W-1:0]            freq,
    output logic [TS_W-1:0]            timeoffset,
    output logic [13:0]                phase,
    output logic                       applied,
    output logic                       late,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [TS_W-1:0] time_mem_r  [0:DEPTH-1];
    logic [TS_W-1:0] freq_mem_r  [0:DEPTH-1];
    logic [13:0]     phase_mem_r [0:DEPTH-1];
    logic            rp_mem_r    [0:DEPTH-1];

    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [LW-1:0]   count_r;

    logic [TS_W-1:0] ts_next_s;
    logic [TS_W-1:0] head_time_s;
    logic            head_valid_s;
    logic            full_s;
    logic            apply_s;
    logic            past_s;
    logic            push_s;

    // Next timestamp, head compare and push/pop qualification.
    always_comb begin
        ts_next_s    = ts_load ? ts_load_value : (timestamp + TS_W'(1));
        head_time_s  = time_mem_r[rd_ptr_r];
        head_valid_s = (count_r != LW'(0));
        full_s       = (count_r == LW'(DEPTH));
        // Unsigned compare with no wrap handling: anything at or behind ts_next is due.
        apply_s      = head_valid_s && (head_time_s <= ts_next_s);
        past_s       = head_valid_s && (head_time_s <  ts_next_s);
        push_s       = cmd_valid && !full_s && !flush;
    end

    assign cmd_ready = !full_s;
    assign level     = count_r;

    // Command storage; contents are don't-care while not counted as queued.
    always_ff @(posedge clk) begin
        if (push_s) begin
            time_mem_r[wr_ptr_r]  <= cmd_time;
            freq_mem_r[wr_ptr_r]  <= cmd_freq;
            phase_mem_r[wr_ptr_r] <= cmd_phase;
            rp_mem_r[wr_ptr_r]    <= cmd_reset_phase;
        end
    end

    // FIFO pointers and occupancy; flush empties the queue but never blocks an apply.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= LW'(0);
        end else if (flush) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= LW'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (apply_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, apply_s})
                2'b10:   count_r <= count_r + LW'(1);
                2'b01:   count_r <= count_r - LW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Timestamp and MAC parameters update on the same edge so they stay aligned.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            timestamp  <= TS_W'(0);
            freq       <= TS_W'(0);
            timeoffset <= TS_W'(0);
            phase      <= 14'd0;
            applied    <= 1'b0;
            late       <= 1'b0;
        end else begin
            timestamp <= ts_next_s;
            applied   <= apply_s;
            late      <= past_s;
            if (apply_s) begin
                freq  <= freq_mem_r[rd_ptr_r];
                phase <= phase_mem_r[rd_ptr_r];
                // Offset chosen so timestamp + timeoffset is zero on the apply cycle.
                if (rp_mem_r[rd_ptr_r]) begin
                    timeoffset <= TS_W'(0) - ts_next_s;
                end
            end
        end
    end

endmodule
